// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: arbitrates instruction- and data-side read requests onto a
// single AXI AR channel. Tracks outstanding reads per ID, blocks data reads
// that hit an in-flight write (RAW), and flags stray read responses.
// Optional: define AXI_ARB_RR_EN to make ties alternate between requesters
// instead of always favouring the data side.
module axi_rd_arbiter #(
  parameter int unsigned MAX_OUTS = 2
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_gnt,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  output logic        data_gnt,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic        rvalid,
  input  logic        rlast,
  output logic        rready,
  input  logic        wr_pend,
  input  logic [31:0] wr_pend_addr,
  output logic        inst_done,
  output logic        data_done,
  output logic        rsp_err
);

  localparam logic [2:0] MaxCnt = 3'(MAX_OUTS);

  typedef enum logic [1:0] {IDLE, INST, DATA} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        id_q, id_d;
  logic [2:0]  icnt_q, icnt_d;
  logic [2:0]  dcnt_q, dcnt_d;
  logic        err_q, err_d;
`ifdef AXI_ARB_RR_EN
  logic        last_data_q, last_data_d;
`endif

  logic inst_elig, data_elig, tie_to_data, hazard, hs;
  logic i_live, d_live, inst_ret, data_ret;
  logic unused_bits;

  // Word-granular hazard compare: the low address bits are deliberately ignored.
  assign unused_bits = ^wr_pend_addr[1:0];

  assign rready  = 1'b1;
  assign arid    = {3'b000, id_q};
  assign araddr  = addr_q;
  assign rsp_err = err_q;

  // AR-side status: eligibility, RAW hazard, arvalid and handshake.
  always_comb begin
    inst_elig = inst_req & (icnt_q < MaxCnt);
    data_elig = data_req & (dcnt_q < MaxCnt);
    hazard    = wr_pend & (addr_q[31:2] == wr_pend_addr[31:2]);
    arvalid   = (state_q == INST) | ((state_q == DATA) & ~hazard);
    hs        = arvalid & arready;
`ifdef AXI_ARB_RR_EN
    tie_to_data = ~last_data_q;
`else
    tie_to_data = 1'b1;
`endif
  end

  // Next-state, grant pulses and address/ID capture.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    id_d     = id_q;
    inst_gnt = 1'b0;
    data_gnt = 1'b0;
`ifdef AXI_ARB_RR_EN
    last_data_d = last_data_q;
`endif
    unique case (state_q)
      IDLE: begin
        // Grants are suppressed while reset is asserted.
        if (aresetn && data_elig && (!inst_elig || tie_to_data)) begin
          data_gnt = 1'b1;
          state_d  = DATA;
          addr_d   = data_addr;
          id_d     = 1'b1;
`ifdef AXI_ARB_RR_EN
          last_data_d = 1'b1;
`endif
        end else if (aresetn && inst_elig) begin
          inst_gnt = 1'b1;
          state_d  = INST;
          addr_d   = inst_addr;
          id_d     = 1'b0;
`ifdef AXI_ARB_RR_EN
          last_data_d = 1'b0;
`endif
        end
      end
      INST, DATA: begin
        if (hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outstanding-read counters, completion pulses and stray-response flag.
  always_comb begin
    i_live    = (icnt_q != 3'd0);
    d_live    = (dcnt_q != 3'd0);
    inst_done = rvalid & rlast & (rid == 4'd0) & i_live;
    data_done = rvalid & rlast & (rid == 4'd1) & d_live;
    inst_ret  = inst_done;
    data_ret  = data_done;
    err_d     = err_q | (rvalid & ((rid[3:1] != 3'd0) | (rid[0] ? ~d_live : ~i_live)));
    icnt_d    = icnt_q;
    dcnt_d    = dcnt_q;
    if (hs && !id_q && !inst_ret) icnt_d = icnt_q + 3'd1;
    else if (!(hs && !id_q) && inst_ret) icnt_d = icnt_q - 3'd1;
    if (hs && id_q && !data_ret) dcnt_d = dcnt_q + 3'd1;
    else if (!(hs && id_q) && data_ret) dcnt_d = dcnt_q - 3'd1;
  end

  // State registers; reset drops any pending AR with no replay.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      id_q    <= 1'b0;
      icnt_q  <= '0;
      dcnt_q  <= '0;
      err_q   <= 1'b0;
`ifdef AXI_ARB_RR_EN
      last_data_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      icnt_q  <= icnt_d;
      dcnt_q  <= dcnt_d;
      err_q   <= err_d;
`ifdef AXI_ARB_RR_EN
      last_data_q <= last_data_d;
`endif
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Testbench for axi_rd_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_axi_rd_arbiter;

  localparam int unsigned MAX_OUTS = 2;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        inst_req, data_req, inst_gnt, data_gnt;
  logic [31:0] inst_addr, data_addr, araddr, wr_pend_addr;
  logic [3:0]  arid, rid;
  logic        arvalid, arready, rvalid, rlast, rready, wr_pend;
  logic        inst_done, data_done, rsp_err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model: at most one accepted-but-unissued read, plus per-ID counts.
  bit          m_pv, m_pid, m_id, m_err, m_last_data;
  logic [31:0] m_addr;
  int          m_cnt[2];

  axi_rd_arbiter #(.MAX_OUTS(MAX_OUTS)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
    .data_req(data_req), .data_addr(data_addr), .data_gnt(data_gnt),
    .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rvalid(rvalid), .rlast(rlast), .rready(rready),
    .wr_pend(wr_pend), .wr_pend_addr(wr_pend_addr),
    .inst_done(inst_done), .data_done(data_done), .rsp_err(rsp_err)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pv = 0; m_pid = 0; m_id = 0; m_err = 0; m_last_data = 0;
    m_addr = '0; m_cnt[0] = 0; m_cnt[1] = 0;
  endtask

  task automatic clear_inputs();
    inst_req = 0; data_req = 0; inst_addr = '0; data_addr = '0;
    arready = 0; rid = '0; rvalid = 0; rlast = 0;
    wr_pend = 0; wr_pend_addr = '0;
  endtask

  // Called from the post-edge phase; leaves the bench one step after a rising edge.
  task automatic do_reset();
    clear_inputs();
    aresetn = 0;
    model_reset();
    #2;
    check("rst_arvalid", {31'd0, arvalid}, 32'd0);
    check("rst_araddr", araddr, 32'd0);
    check("rst_arid", {28'd0, arid}, 32'd0);
    check("rst_err", {31'd0, rsp_err}, 32'd0);
    @(negedge aclk);
    aresetn = 1;
    @(posedge aclk);
    #1;
  endtask

  // One clock cycle: check outputs against the model, advance the model,
  // then apply requester protocol (drop req once granted) and clear R beats.
  task automatic step();
    bit hz, ev, ei, ed, gi, gd, di, dd, tie_d, bad;
    @(negedge aclk);
    hz = m_pv && m_pid && wr_pend && (m_addr[31:2] == wr_pend_addr[31:2]);
    ev = m_pv && !hz;
    ei = inst_req && (m_cnt[0] < int'(MAX_OUTS));
    ed = data_req && (m_cnt[1] < int'(MAX_OUTS));
`ifdef AXI_ARB_RR_EN
    tie_d = !m_last_data;
`else
    tie_d = 1;
`endif
    gi = 0; gd = 0;
    if (!m_pv) begin
      if (ed && (!ei || tie_d)) gd = 1;
      else if (ei) gi = 1;
    end
    di = rvalid && rlast && (rid == 4'd0) && (m_cnt[0] != 0);
    dd = rvalid && rlast && (rid == 4'd1) && (m_cnt[1] != 0);
    check("arvalid", {31'd0, arvalid}, {31'd0, ev});
    check("araddr", araddr, m_addr);
    check("arid", {28'd0, arid}, {31'd0, m_id});
    check("inst_gnt", {31'd0, inst_gnt}, {31'd0, gi});
    check("data_gnt", {31'd0, data_gnt}, {31'd0, gd});
    check("inst_done", {31'd0, inst_done}, {31'd0, di});
    check("data_done", {31'd0, data_done}, {31'd0, dd});
    check("rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
    check("rready", {31'd0, rready}, 32'd1);
    bad = rvalid && ((rid > 4'd1) || (m_cnt[rid[0]] == 0));
    if (bad) m_err = 1;
    if (di) m_cnt[0]--;
    if (dd) m_cnt[1]--;
    if (ev && arready) begin
      m_cnt[m_pid]++;
      m_pv = 0;
    end
    if (gi || gd) begin
      m_pv = 1; m_pid = gd; m_id = gd; m_last_data = gd;
      m_addr = gd ? data_addr : inst_addr;
    end
    @(posedge aclk);
    #1;
    if (gi) inst_req = 0;
    if (gd) data_req = 0;
    rvalid = 0; rlast = 0;
  endtask

  initial begin
    int unsigned id;
    clear_inputs();
    aresetn = 0;
    @(posedge aclk);
    #1;
    do_reset();

    // Single inst read: grant, then AR issued, then back to idle.
    inst_req = 1; inst_addr = 32'h1C00_0000; arready = 1;
    step();
    check("s1_arvalid", {31'd0, arvalid}, 32'd1);
    check("s1_arid", {28'd0, arid}, 32'd0);
    check("s1_araddr", araddr, 32'h1C00_0000);
    step();
    check("s1_idle", {31'd0, arvalid}, 32'd0);

    // Tie: data first, inst after the data handshake.
    inst_req = 1; inst_addr = 32'h0000_1000; data_req = 1; data_addr = 32'h0000_2000; arready = 0;
    step();
    check("tie_arid", {28'd0, arid}, 32'd1);
    arready = 1;
    step();
    step();
    check("tie_second_arid", {28'd0, arid}, 32'd0);
    step();

    // Inst count now at MAX_OUTS: a further request waits for a return.
    inst_req = 1; inst_addr = 32'h0000_3000;
    step(); step();
    check("max_blocked", {31'd0, inst_gnt}, 32'd0);
    rvalid = 1; rlast = 1; rid = 4'd0;
    step();
    check("max_regrant", {31'd0, inst_gnt}, 32'd1);
    step(); step();

    // RAW hazard holds the data read until the write retires.
    data_req = 1; data_addr = 32'h8000_1004; wr_pend = 1; wr_pend_addr = 32'h8000_1007;
    step(); step(); step();
    check("raw_blocked", {31'd0, arvalid}, 32'd0);
    wr_pend = 0;
    step(); step();

    // Stray data response on a clean reset.
    do_reset();
    rvalid = 1; rlast = 1; rid = 4'd1;
    step();
    check("stray_err", {31'd0, rsp_err}, 32'd1);
    step();

    // Asynchronous reset with an AR waiting on arready.
    do_reset();
    data_req = 1; data_addr = 32'h0000_4000; arready = 0;
    step(); step();
    check("pre_rst_arvalid", {31'd0, arvalid}, 32'd1);
    #2;
    aresetn = 0;
    #1;
    check("async_arvalid", {31'd0, arvalid}, 32'd0);
    check("async_araddr", araddr, 32'd0);
    model_reset();
    @(negedge aclk);
    aresetn = 1;
    @(posedge aclk);
    #1;
    step(); step();

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (!inst_req && $urandom_range(2) == 0) begin
        inst_req = 1; inst_addr = $urandom;
      end
      if (!data_req && $urandom_range(2) == 0) begin
        data_req = 1; data_addr = $urandom;
      end
      arready = ($urandom_range(2) != 0);
      wr_pend = ($urandom_range(3) == 0);
      wr_pend_addr = ($urandom_range(1) == 0) ? (m_addr ^ 32'($urandom_range(3))) : $urandom;
      id = $urandom_range(1);
      if (m_cnt[id] != 0 && $urandom_range(2) == 0) begin
        rvalid = 1; rid = 4'(id); rlast = 1'($urandom_range(1));
      end
      if (n > 400 && $urandom_range(99) == 0) begin
        rvalid = 1; rid = 4'($urandom_range(15)); rlast = 1;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
